// File: rtl/core_pkg.sv
// Shared types for the multi-cycle RV32I control path: FSM states, writeback
// source select and the one-hot instruction class captured in DECODE.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic store;
    logic load;
    logic jalr;
    logic jal;
    logic branch;
    logic shift;
    logic calc;
  } inst_class_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // The decoder raises is_calc alongside is_shift for shifts; fold that pair into one class.
  function automatic inst_class_t classify(input logic calc, input logic shift,
                                           input logic branch, input logic jal,
                                           input logic jalr, input logic load,
                                           input logic store);
    inst_class_t c;
    c.calc   = calc & ~shift;
    c.shift  = shift;
    c.branch = branch;
    c.jal    = jal;
    c.jalr   = jalr;
    c.load   = load;
    c.store  = store;
    return c;
  endfunction

  function automatic logic class_valid(input inst_class_t c);
    return $countones(c) == 1;
  endfunction

endpackage

// File: rtl/core_pc_unit.sv
// Program counter with next-PC selection; the next PC is staged in EXECUTE and
// committed to the architectural PC in WRITEBACK.
module core_pc_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        commit_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        branch_taken_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic        misaligned_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] pc_mux;

  always_comb begin
    if (is_jal_i) begin
      pc_mux = target_i;
    end else if (is_jalr_i) begin
      pc_mux = target_i & 32'hFFFF_FFFE;
    end else if (branch_taken_i) begin
      pc_mux = target_i;
    end else begin
      pc_mux = pc_q + PC_STEP;
    end
    next_pc_d    = load_i ? pc_mux : next_pc_q;
    pc_d         = commit_i ? next_pc_q : pc_q;
    misaligned_o = |pc_mux[1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/core_controller.sv
// Multi-cycle sequencer: fetch, decode-settle, execute, optional memory access, writeback.
// state     | meaning
// FETCH     | imem request held until imem_valid_i, instruction latched
// DECODE    | decoder settles, class flags captured one-hot
// EXECUTE   | next PC staged, alignment checked
// MEM       | dmem request held until dmem_ready_i
// WRITEBACK | register write strobe, PC commit, retire pulse
// TRAP      | halted until reset
module core_controller
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  input  logic        is_calc_i,
  input  logic        is_shift_i,
  input  logic        is_branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        branch_taken_i,
  input  logic [31:0] target_addr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ready_i,
  output logic        regfile_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] pc_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic        trap_o
);

  ctrl_state_e state_q, state_d;
  inst_class_t class_q, class_d, dec_class;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        regfile_we_q, regfile_we_d;
  logic        retire_q, retire_d;
  logic        trap_q, trap_d;
  wb_sel_e     wb_sel_q, wb_sel_d;
  logic        pc_load, pc_commit, pc_misaligned;

  core_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_i        (pc_load),
    .commit_i      (pc_commit),
    .is_jal_i      (class_q.jal),
    .is_jalr_i     (class_q.jalr),
    .branch_taken_i(class_q.branch & branch_taken_i),
    .target_i      (target_addr_i),
    .pc_o          (pc_o),
    .misaligned_o  (pc_misaligned)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    class_d   = class_q;
    instret_d = instret_q;
    pc_load   = 1'b0;
    pc_commit = 1'b0;
    dec_class = classify(is_calc_i, is_shift_i, is_branch_i, is_jal_i,
                         is_jalr_i, is_load_i, is_store_i);

    case (state_q)
      ST_FETCH: begin
        // The request flop gates acceptance so nothing is taken in the cycle leaving reset.
        if (imem_req_q && imem_valid_i) begin
          inst_d  = imem_rdata_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        state_d = class_valid(dec_class) ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        pc_load = 1'b1;
        if (pc_misaligned) begin
          state_d = ST_TRAP;
        end else if (class_q.load || class_q.store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (dmem_ready_i) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_commit = 1'b1;
        instret_d = instret_q + 32'd1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    // Outputs are registered from the next state so they align with the state they describe.
    imem_req_d   = (state_d == ST_FETCH);
    dmem_req_d   = (state_d == ST_MEM);
    dmem_we_d    = dmem_req_d & class_d.store;
    retire_d     = (state_d == ST_WRITEBACK);
    trap_d       = (state_d == ST_TRAP);
    regfile_we_d = retire_d & (class_d.calc | class_d.shift | class_d.load |
                               class_d.jal | class_d.jalr);
    if (class_d.load) begin
      wb_sel_d = WB_MEM;
    end else if (class_d.jal || class_d.jalr) begin
      wb_sel_d = WB_PC4;
    end else begin
      wb_sel_d = WB_ALU;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_FETCH;
      class_q      <= '0;
      inst_q       <= '0;
      instret_q    <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      regfile_we_q <= 1'b0;
      retire_q     <= 1'b0;
      trap_q       <= 1'b0;
      wb_sel_q     <= WB_ALU;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      inst_q       <= inst_d;
      instret_q    <= instret_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      regfile_we_q <= regfile_we_d;
      retire_q     <= retire_d;
      trap_q       <= trap_d;
      wb_sel_q     <= wb_sel_d;
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_o;
  assign inst_o       = inst_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign regfile_we_o = regfile_we_q;
  assign wb_sel_o     = wb_sel_q;
  assign retire_o     = retire_q;
  assign instret_o    = instret_q;
  assign trap_o       = trap_q;

endmodule

// File: doc/core_controller.md
# core_controller

Multi-cycle sequencer for the single-issue RV32I core. Fetches one instruction at a time, presents it to the combinational instruction decoder, and steps the datapath through execute, memory and writeback using the decoder's class flags. It owns the program counter, the instruction-memory and data-memory request handshakes, register-file write enable and writeback-source select, and traps on undecodable instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk_i  in  1  core clock; all state changes on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- imem_req_o  out  1  instruction fetch request, held until accepted.
- imem_addr_o  out  32  fetch address, equal to pc_o.
- imem_valid_i  in  1  fetch data valid; completes the request.
- imem_rdata_i  in  32  fetched instruction word.
- inst_o  out  32  latched instruction, drives decoder inst_i.
- is_calc_i, is_shift_i, is_branch_i, is_jal_i, is_jalr_i, is_load_i, is_store_i  in  1 each  decoder class flags.
- branch_taken_i  in  1  ALU branch comparison result.
- target_addr_i  in  32  jump/branch target from the address adder.
- dmem_req_o  out  1  data access request, held until done.
- dmem_we_o  out  1  1 = store, 0 = load; valid with dmem_req_o.
- dmem_ready_i  in  1  data access complete (single-cycle pulse).
- regfile_we_o  out  1  register-file write strobe.
- wb_sel_o  out  2  writeback source: ALU, MEM, PC4.
- pc_o  out  32  current PC.
- retire_o  out  1  one-cycle pulse per completed instruction.
- instret_o  out  32  retired-instruction count.
- trap_o  out  1  sticky; controller halted.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH: imem_req_o=1. When imem_valid_i=1, latch imem_rdata_i into inst_o and go to DECODE.
- DECODE: one cycle for the decoder and register file to settle. Sample the class flags into a registered one-hot class.
  - Zero flags set, or more than one set (is_calc with is_shift counts as one shift class) -> TRAP.
- EXECUTE: sample target_addr_i and branch_taken_i. Compute the next PC:
  - jal/jalr: target, with bit 0 cleared for jalr.
  - branch and taken: target.
  - otherwise: pc+4, wrapping modulo 2^32.
  - If the next PC has bits [1:0] != 0 -> TRAP.
  - Load/store -> MEM; all other classes -> WRITEBACK.
- MEM: dmem_req_o=1, with dmem_we_o=is_store. Hold until dmem_ready_i=1, then go to WRITEBACK.
- WRITEBACK: one cycle. Load pc_o with the next PC. Pulse retire_o and increment instret_o (wraps). Then go to FETCH.
  - regfile_we_o=1 for calc/shift (wb_sel=ALU), load (MEM), jal/jalr (PC4).
  - regfile_we_o=0 for branch and store.
  - rd=x0 is not special-cased here.
- TRAP: all request/strobe outputs 0, trap_o=1. Only reset exits.
- Inputs are ignored outside the state that consumes them:
  - imem_valid_i outside FETCH.
  - dmem_ready_i outside MEM.

## Timing
- Reset values:
  - state=FETCH, pc_o=RESET_PC, inst_o=0, instret_o=0.
  - imem_req_o, dmem_req_o, dmem_we_o, regfile_we_o, retire_o, trap_o all 0.
  - wb_sel_o=ALU.
- imem_req_o rises in the first cycle after rst_ni deasserts.
- Minimum latency per instruction, with zero-wait memories (valid/ready in the first request cycle):
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load/store: 5 cycles.
- Each memory wait cycle adds one cycle. Request outputs stay stable while waiting.
- regfile_we_o and wb_sel_o are registered (Moore) and valid only during WRITEBACK.
- Reset asserted mid-access:
  - Requests drop immediately (asynchronous).
  - A late imem_valid_i/dmem_ready_i is ignored by the state rule above.

## Structure
- Shared package core_pkg holds:
  - ctrl_state_e enum.
  - wb_sel_e (WB_ALU=2'd0, WB_MEM=2'd1, WB_PC4=2'd2).
  - Instruction-class one-hot typedef.
- One natural sub-module, core_pc_unit: PC register, next-PC mux, +4 adder and alignment check. The FSM, class register and instret counter stay in core_controller.

## Test plan
- Reset with RESET_PC=0x100, ADDI fetched with zero wait -> imem_addr_o=0x100; regfile_we_o=1 with wb_sel_o=ALU in cycle 4; pc_o=0x104; instret_o=1.
- LW with dmem_ready_i delayed 3 cycles -> dmem_req_o=1 and dmem_we_o=0 held 4 cycles; regfile_we_o=1 with wb_sel=MEM; total 8 cycles.
- BEQ with branch_taken_i=1, target=0x200 -> pc_o=0x200, no register write. Same with branch_taken_i=0 -> pc_o=pc+4.
- JALR with target_addr_i=0x301 -> pc_o=0x300, wb_sel=PC4. Target 0x302 -> trap_o=1 and no further imem_req_o.
- Decoder flags all zero (word 0x0000_0000), or is_load and is_store both set -> TRAP from DECODE; instret_o unchanged.
- rst_ni pulsed low during a MEM wait, then a stale dmem_ready_i -> state FETCH, pc_o=RESET_PC, stale ready ignored.
